// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard controller for the in-order RV32I pipeline.
// Tracks destination registers in flight from EX (entry 0) to writeback
// (entry FWD_STAGES). It raises the load-use stall and runs the
// post-redirect flush counter. It also produces the EX forwarding selects.
// Optional build macro PIPE_HAZARD_PERF_EN adds the stall_cycles and
// flush_cycles performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_STAGES  = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int FWD_SEL_W   = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_w_en,
  input  logic                  id_is_load,
  input  logic                  redirect,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles,
`endif
  output logic                  stall,
  output logic                  flush,
  output logic                  ex_valid,
  output logic [FWD_SEL_W-1:0]  ex_fwd_sel_1,
  output logic [FWD_SEL_W-1:0]  ex_fwd_sel_2
);

  // Tracker: entry 0 is EX, entry FWD_STAGES is writeback.
  logic                  ent_valid_reg [0:FWD_STAGES];
  logic [REG_ADDR_W-1:0] ent_rd_reg    [0:FWD_STAGES];
  logic                  ent_w_en_reg  [0:FWD_STAGES];
  logic                  ent_load_reg  [0:FWD_STAGES];

  // Source operands of the instruction sitting in EX.
  logic [REG_ADDR_W-1:0] ex_rs1_reg, ex_rs2_reg;
  logic                  ex_rs1_used_reg, ex_rs2_used_reg;

  logic [2:0]            flush_cnt_reg, flush_cnt_next;
  logic                  accept;
  logic                  load_hazard;
  logic [FWD_STAGES:1]   fwd_ok;
  logic [FWD_STAGES:1]   hit_1, hit_2;

  assign flush    = (flush_cnt_reg != 3'd0);
  assign stall    = id_valid && !flush && load_hazard;
  assign accept   = id_valid && !stall && !flush;
  assign ex_valid = ent_valid_reg[0];

  // Load-use check: a load whose data is not yet forwardable blocks ID.
  always_comb begin
    load_hazard = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (ent_valid_reg[j] && ent_w_en_reg[j] && ent_load_reg[j] &&
          (ent_rd_reg[j] != '0)) begin
        if ((id_rs1_used && (ent_rd_reg[j] == id_rs1_addr)) ||
            (id_rs2_used && (ent_rd_reg[j] == id_rs2_addr)))
          load_hazard = 1'b1;
      end
    end
  end

  // A load can supply a forward only once it is LOAD_LAT stages past EX.
  // A bubble in EX has its used bits cleared, so it never hits.
  generate
    for (genvar gi = 1; gi <= FWD_STAGES; gi++) begin : g_fwd
      assign fwd_ok[gi] = ent_valid_reg[gi] && ent_w_en_reg[gi] &&
                          (ent_rd_reg[gi] != '0) &&
                          (!ent_load_reg[gi] || (gi >= 1 + LOAD_LAT));
      assign hit_1[gi]  = fwd_ok[gi] && ex_rs1_used_reg &&
                          (ent_rd_reg[gi] == ex_rs1_reg);
      assign hit_2[gi]  = fwd_ok[gi] && ex_rs2_used_reg &&
                          (ent_rd_reg[gi] == ex_rs2_reg);
    end
  endgenerate

  // Forward select: the youngest matching producer wins (the smallest k).
  always_comb begin
    ex_fwd_sel_1 = '0;
    ex_fwd_sel_2 = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (hit_1[k]) ex_fwd_sel_1 = FWD_SEL_W'(k);
      if (hit_2[k]) ex_fwd_sel_2 = FWD_SEL_W'(k);
    end
  end

  // Tracker shift: ID feeds entry 0, and the oldest entry retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        ent_valid_reg[k] <= 1'b0;
        ent_rd_reg[k]    <= '0;
        ent_w_en_reg[k]  <= 1'b0;
        ent_load_reg[k]  <= 1'b0;
      end
      ex_rs1_reg      <= '0;
      ex_rs2_reg      <= '0;
      ex_rs1_used_reg <= 1'b0;
      ex_rs2_used_reg <= 1'b0;
    end else begin
      ent_valid_reg[0] <= accept;
      ent_rd_reg[0]    <= id_rd_addr;
      ent_w_en_reg[0]  <= id_reg_w_en;
      ent_load_reg[0]  <= id_is_load;
      ex_rs1_reg       <= id_rs1_addr;
      ex_rs2_reg       <= id_rs2_addr;
      ex_rs1_used_reg  <= accept && id_rs1_used;
      ex_rs2_used_reg  <= accept && id_rs2_used;
      for (int k = 1; k <= FWD_STAGES; k++) begin
        ent_valid_reg[k] <= ent_valid_reg[k-1];
        ent_rd_reg[k]    <= ent_rd_reg[k-1];
        ent_w_en_reg[k]  <= ent_w_en_reg[k-1];
        ent_load_reg[k]  <= ent_load_reg[k-1];
      end
    end
  end

  // Flush counter: a redirect is honoured only when not stalled or flushing.
  always_comb begin
    flush_cnt_next = flush_cnt_reg;
    if (redirect && !stall && !flush)
      flush_cnt_next = 3'(FLUSH_SLOTS);
    else if (flush && !stall)
      flush_cnt_next = flush_cnt_reg - 3'd1;
  end

  // Flush counter register.
  always_ff @(posedge clk) begin
    if (rst) flush_cnt_reg <= 3'd0;
    else     flush_cnt_reg <= flush_cnt_next;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles_reg, flush_cycles_reg;

  // Saturating stall and flush cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      flush_cycles_reg <= '0;
    end else begin
      if (stall && (stall_cycles_reg != '1)) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (flush && (flush_cycles_reg != '1)) flush_cycles_reg <= flush_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_cycles = flush_cycles_reg;
`endif

endmodule
